// File: rtl/hs_bind_monitor_pkg.sv
// Shared types for the valid/ready bind monitor: transfer FSM states, violation codes, stall width.
// Pure declarations; no latency or backpressure of its own.
package hs_mon_pkg;

   typedef enum logic {
      HS_IDLE = 1'b0,
      HS_PEND = 1'b1
   } hs_state_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_DROP  = 2'd1,
      ERR_DATA  = 2'd2,
      ERR_STALL = 2'd3
   } hs_err_e;

   localparam int STALL_CNT_W = 8;

endpackage

// File: rtl/hs_sat_counter.sv
// Saturating up-counter with synchronous clear; count visible one edge after inc/clr.
// clr and inc on the same edge restart the count at 1; holds at all-ones, never wraps.
module hs_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = clr ? '0 : cnt_q;
      if (inc && (cnt_d != {W{1'b1}})) begin
         cnt_d = cnt_d + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hs_bind_monitor.sv
// Passive valid/ready monitor (bind with .*): counts accepted beats, raises sticky protocol flags.
// All outputs registered, visible one edge after the observed event; never drives the channel.
module hs_bind_monitor
   import hs_mon_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic              ready,
   input  logic [DATA_W-1:0] data,
   input  logic              clr,
   output logic [CNT_W-1:0]  xfer_count,
   output logic              err_drop,
   output logic              err_data,
   output logic              err_stall,
   output logic              err_any,
   output logic [1:0]        first_err
);

   localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(MAX_STALL);

   hs_state_e               state_q, state_d;
   logic [DATA_W-1:0]       cap_q, cap_d;
   logic [STALL_CNT_W-1:0]  stall_cnt;
   logic                    err_drop_q, err_drop_d;
   logic                    err_data_q, err_data_d;
   logic                    err_stall_q, err_stall_d;
   logic                    err_any_q, err_any_d;
   hs_err_e                 first_q, first_d;

   logic pend, start_pend, stalled, beat;
   logic ev_drop, ev_data, ev_stall;

   assign pend       = (state_q == HS_PEND);
   assign start_pend = !pend && valid && !ready;
   assign stalled    = pend && valid && !ready;
   assign beat       = valid && ready;
   assign ev_drop    = pend && !valid;
   assign ev_data    = pend && valid && (data != cap_q);
   // Fires only on the transition past the limit, so one long stall reports once.
   assign ev_stall   = stalled && (stall_cnt == STALL_LIMIT);

   hs_sat_counter #(.W(CNT_W)) u_xfer_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (beat && !clr),
      .cnt   (xfer_count)
   );

   // Stall tracking is independent of clr so a pending beat survives a clear.
   hs_sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_pend),
      .inc   (start_pend || stalled),
      .cnt   (stall_cnt)
   );

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      case (state_q)
         HS_IDLE: begin
            if (start_pend) begin
               state_d = HS_PEND;
               cap_d   = data;
            end
         end
         HS_PEND: begin
            if (!valid || ready) begin
               state_d = HS_IDLE;
            end
         end
         default: state_d = HS_IDLE;
      endcase
   end

   always_comb begin
      err_drop_d  = err_drop_q  || ev_drop;
      err_data_d  = err_data_q  || ev_data;
      err_stall_d = err_stall_q || ev_stall;
      first_d     = first_q;
      if (first_q == ERR_NONE) begin
         if (ev_drop) begin
            first_d = ERR_DROP;
         end else if (ev_data) begin
            first_d = ERR_DATA;
         end else if (ev_stall) begin
            first_d = ERR_STALL;
         end
      end
      if (clr) begin
         err_drop_d  = 1'b0;
         err_data_d  = 1'b0;
         err_stall_d = 1'b0;
         first_d     = ERR_NONE;
      end
      err_any_d = err_drop_d || err_data_d || err_stall_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HS_IDLE;
         cap_q       <= '0;
         err_drop_q  <= 1'b0;
         err_data_q  <= 1'b0;
         err_stall_q <= 1'b0;
         err_any_q   <= 1'b0;
         first_q     <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         cap_q       <= cap_d;
         err_drop_q  <= err_drop_d;
         err_data_q  <= err_data_d;
         err_stall_q <= err_stall_d;
         err_any_q   <= err_any_d;
         first_q     <= first_d;
      end
   end

   assign err_drop  = err_drop_q;
   assign err_data  = err_data_q;
   assign err_stall = err_stall_q;
   assign err_any   = err_any_q;
   assign first_err = first_q;

endmodule

// File: tb/tb_hs_bind_monitor.sv
// Directed bench for hs_bind_monitor: vector table plus sequences for saturation, clr and async reset.
// A narrow-counter instance shares the stimulus to exercise saturation.
module tb_hs_bind_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, ready, clr;
   logic [7:0]  data;

   logic [15:0] cnt16;
   logic        drop16, dat16, stall16, any16;
   logic [1:0]  first16;
   logic [3:0]  cnt4;
   logic        drop4, dat4, stall4, any4;
   logic [1:0]  first4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hs_bind_monitor #(.DATA_W(8), .CNT_W(16), .MAX_STALL(15)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .data(data), .clr(clr),
      .xfer_count(cnt16), .err_drop(drop16), .err_data(dat16), .err_stall(stall16),
      .err_any(any16), .first_err(first16)
   );

   hs_bind_monitor #(.DATA_W(8), .CNT_W(4), .MAX_STALL(15)) dut4 (
      .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .data(data), .clr(clr),
      .xfer_count(cnt4), .err_drop(drop4), .err_data(dat4), .err_stall(stall4),
      .err_any(any4), .first_err(first4)
   );

   typedef struct {
      logic        v, r, c;
      logic [7:0]  d;
      logic [15:0] cnt;
      logic        drop, dat, stall, any;
      logic [1:0]  first;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic v, r, input logic [7:0] d, input logic c,
                               input logic [15:0] cnt, input logic drop, dat, stall,
                               input logic [1:0] first);
      vec_t e;
      e.v = v; e.r = r; e.d = d; e.c = c; e.cnt = cnt;
      e.drop = drop; e.dat = dat; e.stall = stall; e.first = first;
      e.any = drop | dat | stall;
      vecs.push_back(e);
   endfunction

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic r, input logic [7:0] d, input logic c);
      valid = v; ready = r; data = d; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input int idx, input logic [15:0] cnt,
                          input logic drop, dat, stall, input logic [1:0] first);
      chk({name, ".count"}, idx, cnt16, cnt);
      chk({name, ".drop"},  idx, 16'(drop16), 16'(drop));
      chk({name, ".data"},  idx, 16'(dat16), 16'(dat));
      chk({name, ".stall"}, idx, 16'(stall16), 16'(stall));
      chk({name, ".any"},   idx, 16'(any16), 16'(drop | dat | stall));
      chk({name, ".first"}, idx, 16'(first16), 16'(first));
   endtask

   initial begin
      rst_n = 1'b0; valid = 1'b0; ready = 1'b0; data = 8'h00; clr = 1'b0;

      // back-to-back beats
      for (int i = 1; i <= 5; i++) add(1, 1, 8'h00, 0, 16'(i), 0, 0, 0, 0);
      add(0, 0, 8'h00, 0, 5, 0, 0, 0, 0);
      // legal 15-cycle stall then accept
      for (int i = 0; i < 15; i++) add(1, 0, 8'hA5, 0, 5, 0, 0, 0, 0);
      add(1, 1, 8'hA5, 0, 6, 0, 0, 0, 0);
      add(0, 0, 8'h00, 0, 6, 0, 0, 0, 0);
      // drop after 2 stalled cycles
      add(1, 0, 8'h11, 0, 6, 0, 0, 0, 0);
      add(1, 0, 8'h11, 0, 6, 0, 0, 0, 0);
      add(0, 0, 8'h11, 0, 6, 1, 0, 0, 1);
      add(0, 0, 8'h00, 0, 6, 1, 0, 0, 1);
      // clr with a same-cycle beat: beat discarded
      add(1, 1, 8'h00, 1, 0, 0, 0, 0, 0);
      // payload change while stalled
      add(1, 0, 8'h3C, 0, 0, 0, 0, 0, 0);
      add(1, 0, 8'h3D, 0, 0, 0, 1, 0, 2);
      add(1, 1, 8'h3D, 0, 1, 0, 1, 0, 2);
      add(0, 0, 8'h00, 0, 1, 0, 1, 0, 2);
      add(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
      // 16-cycle stall: flag on the 16th stalled edge
      for (int i = 0; i < 15; i++) add(1, 0, 8'hA5, 0, 0, 0, 0, 0, 0);
      add(1, 0, 8'hA5, 0, 0, 0, 0, 1, 3);
      add(1, 1, 8'hA5, 0, 1, 0, 0, 1, 3);
      add(0, 0, 8'h00, 0, 1, 0, 0, 1, 3);
      // later drop does not overwrite first_err
      add(1, 0, 8'h05, 0, 1, 0, 0, 1, 3);
      add(0, 0, 8'h05, 0, 1, 1, 0, 1, 3);
      add(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);

      #12;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      chk("reset.count4", 0, 16'(cnt4), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].c);
         chk_all("vec", i, vecs[i].cnt, vecs[i].drop, vecs[i].dat, vecs[i].stall, vecs[i].first);
      end

      // clr while a beat is pending: tracking continues
      step(1, 0, 8'h77, 0);
      step(1, 0, 8'h77, 1);
      chk_all("clr_pend", 0, 0, 0, 0, 0, 0);
      step(1, 1, 8'h77, 0);
      chk_all("clr_pend", 1, 1, 0, 0, 0, 0);

      // saturation on the 4-bit instance
      step(0, 0, 8'h00, 1);
      for (int i = 0; i < 20; i++) step(1, 1, 8'(i), 0);
      chk("sat.count4", 0, 16'(cnt4), 16'd15);
      chk("sat.count16", 0, cnt16, 16'd20);
      step(1, 1, 8'h00, 1);
      chk("satclr.count4", 0, 16'(cnt4), 0);
      chk("satclr.flags4", 0, 16'({drop4, dat4, stall4, any4, first4}), 0);
      chk_all("satclr", 0, 0, 0, 0, 0, 0);

      // async reset in the middle of a pending beat
      step(1, 1, 8'h42, 0);
      step(1, 0, 8'h42, 0);
      step(1, 0, 8'h42, 0);
      chk("pre_rst.count", 0, cnt16, 16'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0, 0);
      chk("async_rst.count4", 0, 16'(cnt4), 0);
      valid = 1'b0; ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 8'h00, 0);
      chk_all("post_rst", 0, 0, 0, 0, 0, 0);
      step(0, 0, 8'h00, 0);
      chk_all("post_rst", 1, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
